// File: rtl/tdf_stream_pkg.sv
// Shared types and constants for the TDF stream fanout.
// Holds the fanout state encoding, the default token width and the token layout.
// No logic lives here.
package tdf_stream_pkg;

  localparam int TDF_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } fanout_state_e;

  // Token as stored in a branch FIFO: EOS flag above the data bits.
  typedef struct packed {
    logic                         eos;
    logic [TDF_DEFAULT_WIDTH-1:0] data;
  } token_t;

endpackage

// File: rtl/tdf_stream_fifo.sv
// Small synchronous FIFO holding DEPTH entries of WIDTH bits; head driven from storage.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full/empty are registered.
module tdf_stream_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push_ok;
  logic             pop_ok;

  // Status flags and head are pure functions of registered state.
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    head_dat = mem_q[rd_ptr_q];
  end

  // Next-state: write at wr_ptr, advance pointers (power-of-2 wrap), track occupancy.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; storage cleared so outputs read zero out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tdf_stream_fanout2.sv
// Replicates one _d/_e/_v/_b token stream onto two independently back-pressured branches.
// Latency: 1 cycle from accept to ox_v, 1 token/cycle sustained, no bypass path.
// Backpressure: in_b from registered state only (reset, non-RUN state, either branch full).
module tdf_stream_fanout2
  import tdf_stream_pkg::*;
#(
  parameter int WIDTH = TDF_DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_e,
  input  logic             in_v,
  output logic             in_b,
  output logic [WIDTH-1:0] o0_d,
  output logic             o0_e,
  output logic             o0_v,
  input  logic             o0_b,
  output logic [WIDTH-1:0] o1_d,
  output logic             o1_e,
  output logic             o1_v,
  input  logic             o1_b
);

  localparam int TW = WIDTH + 1;

  fanout_state_e state_q, state_d;

  logic          accept;
  logic          full0, full1;
  logic          empty0, empty1;
  logic          pop0, pop1;
  logic [TW-1:0] head0, head1;
  logic [TW-1:0] in_tok;

  // Both branches see the same pushed token, EOS flag above the data.
  tdf_stream_fifo #(.WIDTH(TW), .DEPTH(DEPTH)) u_fifo0 (
    .clock    (clock),
    .reset    (reset),
    .push     (accept),
    .push_dat (in_tok),
    .pop      (pop0),
    .full     (full0),
    .empty    (empty0),
    .head_dat (head0)
  );

  tdf_stream_fifo #(.WIDTH(TW), .DEPTH(DEPTH)) u_fifo1 (
    .clock    (clock),
    .reset    (reset),
    .push     (accept),
    .push_dat (in_tok),
    .pop      (pop1),
    .full     (full1),
    .empty    (empty1),
    .head_dat (head1)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: an accepted EOS closes the input; once both branches drain, terminate.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (accept && in_e)    state_d = ST_DRAIN;
      ST_DRAIN: if (empty0 && empty1)  state_d = ST_DONE;
      ST_DONE:                         state_d = ST_DONE;
      default:                         state_d = ST_RUN;
    endcase
  end

  // Outputs: stall upstream from registered status only (plus reset), present FIFO heads.
  always_comb begin
    in_b   = ~reset | (state_q != ST_RUN) | full0 | full1;
    accept = in_v & ~in_b;
    in_tok = {in_e, in_d};
    o0_v   = ~empty0 & (state_q != ST_DONE);
    o1_v   = ~empty1 & (state_q != ST_DONE);
    o0_d   = head0[WIDTH-1:0];
    o0_e   = head0[WIDTH];
    o1_d   = head1[WIDTH-1:0];
    o1_e   = head1[WIDTH];
    pop0   = o0_v & ~o0_b;
    pop1   = o1_v & ~o1_b;
  end

endmodule

// File: tb/tb_tdf_stream_fanout2.sv
// Directed bench for tdf_stream_fanout2 with WIDTH=16, DEPTH=2.
// Transfers are logged at the falling edge, inputs change 1ns after the rising edge.
// Expected token sequences are written out by hand per scenario.
module tb_tdf_stream_fanout2;
  import tdf_stream_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in_d;
  logic        in_e, in_v, in_b;
  logic [15:0] o0_d, o1_d;
  logic        o0_e, o0_v, o0_b;
  logic        o1_e, o1_v, o1_b;

  tdf_stream_fanout2 #(.WIDTH(16), .DEPTH(2)) dut (
    .clock (clock), .reset (reset),
    .in_d  (in_d),  .in_e  (in_e), .in_v (in_v), .in_b (in_b),
    .o0_d  (o0_d),  .o0_e  (o0_e), .o0_v (o0_v), .o0_b (o0_b),
    .o1_d  (o1_d),  .o1_e  (o1_e), .o1_v (o1_v), .o1_b (o1_b)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_acc = 0;
  int occ0  = 0;
  int occ1  = 0;
  int t3_viol = 0;
  bit t3_en = 1'b0;
  bit t3_done = 1'b0;

  token_t q0[$], q1[$], exp_q[$];
  int     acc_cyc[$], c0[$], c1[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Transfer monitor: values seen at the falling edge move on the next rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      occ0 = 0;
      occ1 = 0;
    end else begin
      if (t3_en && in_b && occ0 < 2 && occ1 < 2) t3_viol++;
      if (in_v && !in_b) begin
        n_acc++;
        acc_cyc.push_back(cyc);
        occ0++;
        occ1++;
      end
      if (o0_v && !o0_b) begin
        q0.push_back({o0_e, o0_d});
        c0.push_back(cyc);
        occ0--;
      end
      if (o1_v && !o1_b) begin
        q1.push_back({o1_e, o1_d});
        c1.push_back(cyc);
        occ1--;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic e);
    bit ok = 1'b0;
    in_v = 1'b1;
    in_d = d;
    in_e = e;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (!in_b) ok = 1'b1;
    end
    @(posedge clock);
    #1;
    chk($sformatf("send_%04h_accepted", d), {31'd0, ok}, 32'd1);
  endtask

  task automatic idle(input int n);
    in_v = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_branches(input string tag);
    chk({tag, "_b0_count"}, q0.size(), exp_q.size());
    chk({tag, "_b1_count"}, q1.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_b0_tok%0d", tag, i), (i < q0.size()) ? {15'd0, q0[i]} : 32'hDEAD_BEEF, {15'd0, exp_q[i]});
      chk($sformatf("%s_b1_tok%0d", tag, i), (i < q1.size()) ? {15'd0, q1[i]} : 32'hDEAD_BEEF, {15'd0, exp_q[i]});
    end
    q0.delete();
    q1.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] t3_vec [16];
  int          base;

  initial begin
    t3_vec = '{16'h1234, 16'hBEEF, 16'h0F0F, 16'hA5A5, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF,
               16'h3C3C, 16'hC0DE, 16'h0000, 16'h5A5A, 16'h1111, 16'h2222, 16'hFACE, 16'h0BAD};
    reset = 1'b0; in_v = 1'b0; in_d = '0; in_e = 1'b0; o0_b = 1'b0; o1_b = 1'b0;

    // Reset state
    #3;
    chk("rst_o0_v", o0_v, 0);
    chk("rst_o1_v", o1_v, 0);
    chk("rst_o0_d", o0_d, 0);
    chk("rst_o1_d", o1_d, 0);
    chk("rst_o0_e", o0_e, 0);
    chk("rst_o1_e", o1_e, 0);
    chk("rst_in_b", in_b, 1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #2 chk("rel_in_b", in_b, 0);
    @(posedge clock); #1;

    // 1: back-to-back tokens, no stalls
    acc_cyc.delete(); c0.delete(); c1.delete();
    send(16'h0001, 0); send(16'h0002, 0); send(16'h0003, 0); send(16'h0004, 0);
    idle(6);
    chk("t1_lat_b0",  (c0.size() >= 1 && acc_cyc.size() >= 1) ? c0[0] - acc_cyc[0] : -1, 1);
    chk("t1_lat_b1",  (c1.size() >= 1 && acc_cyc.size() >= 1) ? c1[0] - acc_cyc[0] : -1, 1);
    chk("t1_acc_rate", (acc_cyc.size() >= 4) ? acc_cyc[3] - acc_cyc[0] : -1, 3);
    chk("t1_b0_rate", (c0.size() >= 4) ? c0[3] - c0[0] : -1, 3);
    chk("t1_b1_rate", (c1.size() >= 4) ? c1[3] - c1[0] : -1, 3);
    for (int i = 1; i <= 4; i++) exp_q.push_back({1'b0, 16'(i)});
    check_branches("t1");

    // 2: branch 0 stalled, branch 1 keeps draining until branch 0 fills
    o0_b = 1'b1;
    base = n_acc;
    send(16'h0010, 0); send(16'h0011, 0);
    in_v = 1'b1; in_d = 16'h0012; in_e = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("t2_stall_in_b", in_b, 1);
    chk("t2_stall_accepts", n_acc - base, 2);
    chk("t2_b1_passed", q1.size(), 2);
    chk("t2_b0_held", q0.size(), 0);
    o0_b = 1'b0;
    send(16'h0012, 0); send(16'h0013, 0); send(16'h0014, 0);
    idle(6);
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 16'h0010 + 16'(i)});
    check_branches("t2");

    // 3: alternating consumer stalls
    t3_viol = 0;
    t3_en = 1'b1;
    t3_done = 1'b0;
    o0_b = 1'b1; o1_b = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(t3_vec[i], 0);
        in_v = 1'b0;
        t3_done = 1'b1;
      end
      begin
        while (!t3_done) begin
          @(posedge clock);
          #1;
          o0_b = ~o0_b;
          o1_b = ~o0_b;
        end
      end
    join
    o0_b = 1'b0; o1_b = 1'b0;
    idle(8);
    t3_en = 1'b0;
    chk("t3_spurious_in_b", t3_viol, 0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, t3_vec[i]});
    check_branches("t3");

    // 4: EOS propagation, drain and terminate
    send(16'h00AA, 0);
    send(16'h0000, 1);
    chk("t4_in_b_after_eos", in_b, 1);
    in_v = 1'b1; in_d = 16'h0077; in_e = 1'b0;
    base = n_acc;
    repeat (10) @(posedge clock);
    #1;
    chk("t4_done_o0_v", o0_v, 0);
    chk("t4_done_o1_v", o1_v, 0);
    chk("t4_done_in_b", in_b, 1);
    chk("t4_no_accept", n_acc - base, 0);
    exp_q.push_back({1'b0, 16'h00AA});
    exp_q.push_back({1'b1, 16'h0000});
    check_branches("t4");

    // 5: reset mid-stream with both branches full
    in_v = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    o0_b = 1'b1; o1_b = 1'b1;
    send(16'h0031, 0); send(16'h0032, 0);
    in_v = 1'b0;
    chk("t5_full_in_b", in_b, 1);
    chk("t5_full_o0_v", o0_v, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_o0_v", o0_v, 0);
    chk("t5_rst_o1_v", o1_v, 0);
    chk("t5_rst_in_b", in_b, 1);
    chk("t5_rst_o0_d", o0_d, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    q0.delete(); q1.delete();
    o0_b = 1'b0; o1_b = 1'b0;
    #1;
    chk("t5_rel_in_b", in_b, 0);
    chk("t5_rel_o0_v", o0_v, 0);
    chk("t5_rel_o1_v", o1_v, 0);
    send(16'h0055, 0);
    idle(5);
    exp_q.push_back({1'b0, 16'h0055});
    check_branches("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdf_stream_fanout2.md
Name: tdf_stream_fanout2

Overview:
- TDF stream fanout: consumes one `_d/_e/_v/_b` token stream and replicates every token onto two independent output streams.
- Sits between one producing operator and two consuming operators, so one result stream can feed two operators with independent back-pressure.
- Each branch has its own small FIFO, so a stall on one consumer does not stall the other until that branch's FIFO fills.
- Propagates end-of-stream, then drains and terminates.

Parameters:
- WIDTH, 16, data bits per token
- DEPTH, 2, tokens per branch FIFO (power of 2, >=2)

Ports:
- clock  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- in_d  input  WIDTH  input token data
- in_e  input  1  input token is end-of-stream marker (qualified by in_v)
- in_v  input  1  input token valid
- in_b  output  1  back-pressure to upstream producer (1 = stall)
- o0_d  output  WIDTH  branch 0 token data
- o0_e  output  1  branch 0 end-of-stream marker
- o0_v  output  1  branch 0 token valid
- o0_b  input  1  branch 0 consumer back-pressure
- o1_d  output  WIDTH  branch 1 token data
- o1_e  output  1  branch 1 end-of-stream marker
- o1_v  output  1  branch 1 token valid
- o1_b  input  1  branch 1 consumer back-pressure

Behaviour:
- Transfer rule (all streams): token moves on a rising edge where `_v=1` and `_b=0`. Producer holds `_d/_e` stable while `_v=1` and `_b=1`. A token with `_e=1` is an EOS marker; its `_d` is don't-care but is copied unchanged.
- Reset (reset=0, async):
  - both FIFOs emptied; state=RUN
  - o0_v=o1_v=0, o0_d=o1_d=0, o0_e=o1_e=0
  - in_b=1 while reset is asserted; in_b=0 on the first cycle after release
- Accept:
  - condition: in_v & ~in_b
  - in_b = (state!=RUN) | full0 | full1, computed from registered state only; no combinational path from in_v, o0_b or o1_b.
  - An accepted token is pushed into both FIFOs on the same edge, as {in_e, in_d}.
- Output side, per branch x:
  - ox_v = ~emptyx; ox_d/ox_e = FIFO head, driven from storage.
  - Pop on ox_v & ~ox_b.
- Latency and throughput: 1 cycle from accept to ox_v. No bypass. Sustained throughput is 1 token/cycle when neither consumer stalls.
- Push and pop on the same FIFO in the same cycle:
  - count unchanged, head advances
  - legal when not full
  - when full, the push is blocked by in_b (registered full), so a full FIFO costs one bubble.
- Branch independence: o0_b held at 1 lets branch 1 keep draining; input stalls only when branch 0 holds DEPTH tokens.
- State machine:
  - RUN: accepting. Accepting a token with in_e=1 -> DRAIN.
  - DRAIN: in_b=1; no further accepts. Both FIFOs empty (both EOS tokens popped) -> DONE.
  - DONE: in_b=1, o0_v=o1_v=0; stays until reset.
- Pointers: read/write pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits; full = (count==DEPTH), empty = (count==0).
- Reset mid-stream: all buffered tokens are discarded, with no partial output; in_b returns to 0 after release.

Decomposition:
- Shared package `tdf_stream_pkg`:
  - fanout state encoding (RUN=2'd0, DRAIN=2'd1, DONE=2'd2)
  - default WIDTH constant
  - token struct {eos, data}
- Natural sub-module `tdf_stream_fifo`:
  - parameters WIDTH+1, DEPTH
  - push/pop/full/empty, head output, async active-low reset
  - instantiated twice
- Top level holds the state machine and the in_b logic.

Test Plan:
1. Reset release, send tokens 0x0001..0x0004 back-to-back, o0_b=o1_b=0 -> both branches emit 0x0001..0x0004 in order, first ox_v one cycle after first accept, one token/cycle, in_b stays 0.
2. o0_b held 1, send 5 tokens 0x0010..0x0014 -> branch 1 emits all tokens as they are accepted; in_b rises after 2 accepts (DEPTH=2) while o0_b=1; after o0_b released branch 0 emits 0x0010..0x0014 in order, no loss or duplication.
3. Alternating o0_b/o1_b toggles each cycle, 16 random tokens -> both output sequences equal the input sequence; in_b never 1 while both FIFOs have space.
4. Send 0x00AA then EOS token (in_e=1, in_d=0x0000) -> both branches emit 0x00AA then e=1; in_b=1 from the cycle after EOS accept; after both EOS popped, state DONE, in_v held 1 thereafter is never accepted.
5. Fill both FIFOs (o0_b=o1_b=1), assert reset=0 mid-stream for 1 cycle -> o0_v=o1_v=0 and in_b=1 immediately (async); after release FIFOs are empty, in_b=0, and the next token 0x0055 appears alone on both outputs.
